// File: rtl/ddr_cmd_sched.sv
// DDR2 command scheduler: arbitrates write bursts against read requests and
// hands out ring-buffer burst addresses to the memory controller user interface.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for calibration and room in the controller FIFOs
//   ARB      | choosing between an eligible write burst and a read
//   WR_BURST | streaming WORDS beats; the first beat carries the command
//   RD_CMD   | one-cycle read command with rd_ack
module ddr_cmd_sched #(
    parameter int DATA_WIDTH  = 64,
    parameter int WRITE_BURST = 8,
    parameter int ADDR_WIDTH  = 31,
    parameter int ADDR_BASE   = 0,
    parameter int ADDR_SPAN   = 1024,
    parameter int CNT_W       = 10,
    parameter int RD_PRIORITY = 1
) (
    input  logic                        sys_clk,
    input  logic                        reset_n,
    input  logic                        phy_init_done,
    input  logic                        app_wdf_afull,
    input  logic                        app_af_afull,
    input  logic [CNT_W-1:0]            wr_fifo_count,
    input  logic                        rd_req,
    output logic                        wr_fifo_rd,
    output logic                        app_wdf_wren,
    output logic                        app_af_wren,
    output logic [2:0]                  app_af_cmd,
    output logic [ADDR_WIDTH-1:0]       app_af_addr,
    output logic                        rd_ack,
    output logic [$clog2(ADDR_SPAN):0]  fill_level
);

    localparam int WORDS  = WRITE_BURST / 2;
    localparam int PTR_W  = $clog2(ADDR_SPAN);
    localparam int FILL_W = PTR_W + 1;
    localparam int BEAT_W = $clog2(WORDS);

    localparam logic [CNT_W:0]      WORDS_C = (CNT_W+1)'(WORDS);
    localparam logic [FILL_W-1:0]   SPAN_C  = FILL_W'(ADDR_SPAN);
    localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(WORDS - 1);
    localparam logic [2:0]          CMD_WR  = 3'b000;
    localparam logic [2:0]          CMD_RD  = 3'b001;

    // Reject configurations the ring/beat arithmetic cannot represent.
    if (WRITE_BURST < 4 || (WRITE_BURST % 2) != 0 || ADDR_SPAN < 2 || DATA_WIDTH < 1) begin : g_bad_params
        $error("ddr_cmd_sched: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARB      = 2'd1,
        WR_BURST = 2'd2,
        RD_CMD   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   tok_wr_q, tok_wr_d;
    logic                   wr_fifo_rd_q, wr_fifo_rd_d;
    logic                   app_wdf_wren_q;
    logic                   af_wren_q, af_wren_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   rd_ack_q, rd_ack_d;

    logic                   ok, wr_ok, rd_ok, pick_rd, beat_go;
    logic [ADDR_WIDTH-1:0]  wr_addr, rd_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ADDR_SPAN - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ok      = !app_af_afull && !app_wdf_afull;
    assign wr_ok   = ({1'b0, wr_fifo_count} >= WORDS_C) && (fill_q < SPAN_C);
    assign rd_ok   = rd_req && (fill_q != '0);
    assign wr_addr = ADDR_WIDTH'(ADDR_BASE) + ADDR_WIDTH'(wr_ptr_q) * ADDR_WIDTH'(WRITE_BURST);
    assign rd_addr = ADDR_WIDTH'(ADDR_BASE) + ADDR_WIDTH'(rd_ptr_q) * ADDR_WIDTH'(WRITE_BURST);

    // Next-state, pointer, occupancy and output decode.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        beat_d       = beat_q;
        tok_wr_d     = tok_wr_q;
        wr_fifo_rd_d = 1'b0;
        af_wren_d    = 1'b0;
        cmd_d        = 3'b000;
        addr_d       = '0;
        rd_ack_d     = 1'b0;
        pick_rd      = 1'b0;
        beat_go      = 1'b0;

        case (state_q)
            IDLE: begin
                if (phy_init_done && ok) state_d = ARB;
            end
            ARB: begin
                if (!phy_init_done) begin
                    state_d = IDLE;
                end else if (ok && (wr_ok || rd_ok)) begin
                    // Token set means the write side is owed the next tie.
                    pick_rd = rd_ok && (!wr_ok || (RD_PRIORITY != 0) || !tok_wr_q);
                    if (pick_rd) begin
                        state_d  = RD_CMD;
                        tok_wr_d = 1'b1;
                    end else begin
                        state_d  = WR_BURST;
                        tok_wr_d = 1'b0;
                    end
                end
            end
            WR_BURST: begin
                // The command rides on the first beat, so that beat also needs address-FIFO room.
                beat_go = !app_wdf_afull && ((beat_q != '0) || !app_af_afull);
                if (beat_go) begin
                    wr_fifo_rd_d = 1'b1;
                    if (beat_q == '0) begin
                        af_wren_d = 1'b1;
                        cmd_d     = CMD_WR;
                        addr_d    = wr_addr;
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d   = '0;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        fill_d   = fill_q + 1'b1;
                        state_d  = ARB;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RD_CMD: begin
                af_wren_d = 1'b1;
                cmd_d     = CMD_RD;
                addr_d    = rd_addr;
                rd_ack_d  = 1'b1;
                rd_ptr_d  = ptr_inc(rd_ptr_q);
                fill_d    = fill_q - 1'b1;
                state_d   = ARB;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; app_wdf_wren trails the FIFO read by its one-cycle latency.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            beat_q         <= '0;
            tok_wr_q       <= 1'b1;
            wr_fifo_rd_q   <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            af_wren_q      <= 1'b0;
            cmd_q          <= 3'b000;
            addr_q         <= '0;
            rd_ack_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_q         <= fill_d;
            beat_q         <= beat_d;
            tok_wr_q       <= tok_wr_d;
            wr_fifo_rd_q   <= wr_fifo_rd_d;
            app_wdf_wren_q <= wr_fifo_rd_q;
            af_wren_q      <= af_wren_d;
            cmd_q          <= cmd_d;
            addr_q         <= addr_d;
            rd_ack_q       <= rd_ack_d;
        end
    end

    assign wr_fifo_rd   = wr_fifo_rd_q;
    assign app_wdf_wren = app_wdf_wren_q;
    assign app_af_wren  = af_wren_q;
    assign app_af_cmd   = cmd_q;
    assign app_af_addr  = addr_q;
    assign rd_ack       = rd_ack_q;
    assign fill_level   = fill_q;

endmodule

// File: doc/ddr_cmd_sched.md
Name: ddr_cmd_sched

Overview:
Parametrised DDR2 command scheduler. It sits between the write-data FIFO / read requesters and the memory controller user interface (address FIFO plus write-data FIFO). It arbitrates write bursts against read requests and generates ring-buffer burst addresses with automatic wrap-around. It tracks the occupancy of the stored bursts so that a read never overtakes a write.

Parameters:
DATA_WIDTH, 64, width of a write-data FIFO word (informational; no data passes through this block)
WRITE_BURST, 8, DDR burst length in beats; WORDS = WRITE_BURST/2 FIFO words per burst; must be an even number >= 4
ADDR_WIDTH, 31, width of app_af_addr
ADDR_BASE, 0, first address of the ring buffer
ADDR_SPAN, 1024, ring depth in bursts; must be >= 2 (not required to be a power of two)
CNT_W, 10, width of wr_fifo_count
RD_PRIORITY, 1, 1 = reads always win arbitration; 0 = round-robin between read and write

Ports:
sys_clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
phy_init_done  in  1  memory calibration complete
app_wdf_afull  in  1  controller write-data FIFO almost full
app_af_afull  in  1  controller address FIFO almost full
wr_fifo_count  in  CNT_W  number of words in the write-data FIFO
rd_req  in  1  level; one-burst read request, held until rd_ack
wr_fifo_rd  out  1  write-data FIFO read strobe
app_wdf_wren  out  1  wr_fifo_rd delayed one cycle (FIFO read latency)
app_af_wren  out  1  command strobe
app_af_cmd  out  3  3'b000 = write, 3'b001 = read
app_af_addr  out  ADDR_WIDTH  burst start address
rd_ack  out  1  one-cycle pulse, coincident with the read command
fill_level  out  log2(ADDR_SPAN)+1  number of bursts written and not yet read

Behaviour:
- Reset (reset_n = 0, asynchronous, at any time including mid-burst):
  - All outputs go to 0; wr_ptr, rd_ptr, fill_level and the beat counter go to 0.
  - The state goes to IDLE and the round-robin token goes to write.
- Derived conditions:
  - ok = !app_af_afull && !app_wdf_afull
  - wr_ok = (wr_fifo_count >= WORDS) && (fill_level < ADDR_SPAN)
  - rd_ok = rd_req && (fill_level != 0)
- State IDLE: move to ARB when phy_init_done && ok.
- State ARB:
  - If phy_init_done is 0, go to IDLE.
  - Else if ok and both wr_ok and rd_ok are true, the winner is the read when RD_PRIORITY = 1. When RD_PRIORITY = 0, the winner is whichever type did not win last.
  - A single eligible request wins on its own. With none eligible, stay in ARB.
  - Write winner goes to WR_BURST; read winner goes to RD_CMD.
- State WR_BURST:
  - Issues WORDS beats. A beat (wr_fifo_rd = 1) occurs only in cycles where !app_wdf_afull; otherwise the beat is held and the beat count does not advance.
  - The first beat also asserts app_af_wren with app_af_cmd = 000 and app_af_addr = ADDR_BASE + wr_ptr*WRITE_BURST. If app_af_afull is 1 on that cycle, the first beat is held.
  - After the final beat: wr_ptr advances, wrapping from ADDR_SPAN-1 to 0; fill_level increments; state returns to ARB.
  - A phy_init_done drop during a burst does not abort it.
- State RD_CMD (one cycle):
  - Asserts app_af_wren, app_af_cmd = 001, app_af_addr = ADDR_BASE + rd_ptr*WRITE_BURST, and rd_ack.
  - rd_ptr advances with wrap; fill_level decrements; state returns to ARB.
- Command rules:
  - At most one command per cycle, so fill_level never increments and decrements in the same cycle.
  - fill_level stays within 0..ADDR_SPAN.
- Blocking:
  - When the ring is full, writes stall.
  - When the ring is empty, rd_req stays pending with no ack.
- Requester rule: the requester deasserts rd_req the cycle after rd_ack. If rd_req is still high, it is a new request.
- Timing: outputs are registered. First command appears 2 cycles after the arbitration condition is met (ARB registers the decision, then the command state drives the registered outputs).

Test Plan:
1. Reset released, phy_init_done = 1, wr_fifo_count = 4, WRITE_BURST = 8 -> one write command at address 0, exactly 4 wr_fifo_rd pulses, app_wdf_wren lagging by 1 cycle, fill_level = 1.
2. Three writes then rd_req held -> read command at address 0 with rd_ack; next read at address 8; fill_level goes 3 -> 2 -> 1.
3. ADDR_SPAN = 4: perform 4 writes and 4 reads, then 1 more write -> the fifth write address wraps to ADDR_BASE + 0. A write attempted with fill_level = 4 is not issued.
4. rd_req with fill_level = 0 -> no command, no rd_ack until a write completes; then the read is issued at the write's address.
5. app_wdf_afull pulsed for 3 cycles mid-burst -> beats pause; the burst still totals WORDS beats; exactly one write command is issued.
6. RD_PRIORITY = 0 with both requests eligible continuously -> commands alternate W, R, W, R. reset_n asserted mid-burst -> all outputs are 0 immediately.
